// File: rtl/llc_mshr_array.sv
// llc_mshr_array: LLC miss-status holding register array.
// Tracks up to N_MSHR outstanding line transactions. Each entry carries a
// line address, an unstable state, a requestor id and a signed invalidation
// ack counter. An entry whose counter reaches zero is queued on the done
// port until the LLC FSM takes it; the entry then stays valid until freed.
//
// Optional feature macro: LLC_MSHR_WORD_MASK_EN adds a per-entry word mask
// (alloc_word_mask / upd_word_mask / rd_word_mask).
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high (alloc_valid/alloc_ready, done_valid/done_ready).
// Valid never depends on ready in the same cycle. Strobes without a ready
// (upd/ack/free) always take effect, but only on a valid entry.
module llc_mshr_array #(
    parameter int N_MSHR   = 8,
    parameter int ADDR_W   = 26,
    parameter int STATE_W  = 3,
    parameter int REQ_ID_W = 4,
    parameter int CNT_W    = 5,
    parameter int WORDS    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [ADDR_W-1:0]          alloc_addr,
    input  logic [STATE_W-1:0]         alloc_state,
    input  logic [REQ_ID_W-1:0]        alloc_req_id,
    input  logic [CNT_W-1:0]           alloc_invack,
    output logic [$clog2(N_MSHR)-1:0]  alloc_idx,
    input  logic [ADDR_W-1:0]          lookup_addr,
    output logic                       lookup_hit,
    output logic [$clog2(N_MSHR)-1:0]  lookup_idx,
    input  logic [$clog2(N_MSHR)-1:0]  rd_idx,
    output logic [STATE_W-1:0]         rd_state,
    output logic [REQ_ID_W-1:0]        rd_req_id,
    output logic [CNT_W-1:0]           rd_invack,
    input  logic                       upd_valid,
    input  logic [$clog2(N_MSHR)-1:0]  upd_idx,
    input  logic [STATE_W-1:0]         upd_state,
    input  logic                       ack_valid,
    input  logic [$clog2(N_MSHR)-1:0]  ack_idx,
    input  logic                       free_valid,
    input  logic [$clog2(N_MSHR)-1:0]  free_idx,
    output logic                       done_valid,
    output logic [$clog2(N_MSHR)-1:0]  done_idx,
    input  logic                       done_ready,
    output logic [$clog2(N_MSHR):0]    mshr_cnt,
    output logic                       full,
    output logic                       empty
`ifdef LLC_MSHR_WORD_MASK_EN
    ,
    input  logic [WORDS-1:0]           alloc_word_mask,
    input  logic [WORDS-1:0]           upd_word_mask,
    output logic [WORDS-1:0]           rd_word_mask
`endif
);

    localparam int IDX_W = $clog2(N_MSHR);

    // Entry lifecycle: WAIT = acks outstanding, DONE = queued on done port,
    // HELD = handed to the FSM, waiting for free.
    typedef enum logic [1:0] {
        E_FREE = 2'd0,
        E_WAIT = 2'd1,
        E_DONE = 2'd2,
        E_HELD = 2'd3
    } entry_st_e;

    entry_st_e            st_q     [N_MSHR];
    entry_st_e            st_d     [N_MSHR];
    logic [ADDR_W-1:0]    addr_q   [N_MSHR];
    logic [ADDR_W-1:0]    addr_d   [N_MSHR];
    logic [STATE_W-1:0]   state_q  [N_MSHR];
    logic [STATE_W-1:0]   state_d  [N_MSHR];
    logic [REQ_ID_W-1:0]  req_id_q [N_MSHR];
    logic [REQ_ID_W-1:0]  req_id_d [N_MSHR];
    logic [CNT_W-1:0]     cnt_q    [N_MSHR];
    logic [CNT_W-1:0]     cnt_d    [N_MSHR];
`ifdef LLC_MSHR_WORD_MASK_EN
    logic [WORDS-1:0]     mask_q   [N_MSHR];
    logic [WORDS-1:0]     mask_d   [N_MSHR];
`else
    localparam int unused_words = WORDS;
`endif

    logic [N_MSHR-1:0]    valid;
    logic [N_MSHR-1:0]    pending;
    logic [N_MSHR-1:0]    alloc_hit_v;
    logic [N_MSHR-1:0]    ack_hit_v;
    logic [N_MSHR-1:0]    upd_hit_v;
    logic [N_MSHR-1:0]    free_hit_v;
    logic [N_MSHR-1:0]    done_hit_v;
    logic [N_MSHR-1:0]    ack_zero_v;
    logic                 alloc_conflict;
    logic                 alloc_fire;
    logic                 done_fire;

    // Per-entry status flags decoded from the lifecycle state.
    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            valid[i]   = (st_q[i] != E_FREE);
            pending[i] = (st_q[i] == E_DONE);
        end
    end

    // Address match, lowest-free, lowest-pending selection and occupancy.
    always_comb begin
        lookup_hit     = 1'b0;
        lookup_idx     = '0;
        alloc_conflict = 1'b0;
        alloc_idx      = '0;
        done_valid     = 1'b0;
        done_idx       = '0;
        mshr_cnt       = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            if (valid[i] && addr_q[i] == lookup_addr && !lookup_hit) begin
                lookup_hit = 1'b1;
                lookup_idx = IDX_W'(i);
            end
            if (valid[i] && addr_q[i] == alloc_addr) begin
                alloc_conflict = 1'b1;
            end
            mshr_cnt = mshr_cnt + {{IDX_W{1'b0}}, valid[i]};
        end
        // Search downward so the lowest index wins.
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
            if (pending[i]) begin
                done_valid = 1'b1;
                done_idx   = IDX_W'(i);
            end
        end
    end

    assign full        = (mshr_cnt == (IDX_W+1)'(N_MSHR));
    assign empty       = (mshr_cnt == '0);
    // Registered state only: a free in this cycle cannot unblock a full array.
    assign alloc_ready = !full && !alloc_conflict;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign done_fire   = done_valid && done_ready;

    assign rd_state    = state_q[rd_idx];
    assign rd_req_id   = req_id_q[rd_idx];
    assign rd_invack   = cnt_q[rd_idx];
`ifdef LLC_MSHR_WORD_MASK_EN
    assign rd_word_mask = mask_q[rd_idx];
`endif

    // Per-entry event decode; strobes to invalid entries are dropped here.
    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            alloc_hit_v[i] = alloc_fire && (alloc_idx == IDX_W'(i));
            ack_hit_v[i]   = ack_valid  && (ack_idx  == IDX_W'(i)) && valid[i];
            upd_hit_v[i]   = upd_valid  && (upd_idx  == IDX_W'(i)) && valid[i];
            free_hit_v[i]  = free_valid && (free_idx == IDX_W'(i)) && valid[i];
            done_hit_v[i]  = done_fire  && (done_idx == IDX_W'(i));
            ack_zero_v[i]  = ack_hit_v[i] && ((cnt_q[i] - CNT_W'(1)) == '0);
        end
    end

    // Next-state for every entry: lifecycle transition plus payload updates.
    always_comb begin
        for (int i = 0; i < N_MSHR; i++) begin
            st_d[i]     = st_q[i];
            addr_d[i]   = addr_q[i];
            state_d[i]  = state_q[i];
            req_id_d[i] = req_id_q[i];
            cnt_d[i]    = cnt_q[i];
`ifdef LLC_MSHR_WORD_MASK_EN
            mask_d[i]   = mask_q[i];
            if (upd_hit_v[i]) begin
                mask_d[i] = mask_q[i] | upd_word_mask;
            end
`endif
            if (upd_hit_v[i]) begin
                state_d[i] = upd_state;
            end
            if (ack_hit_v[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end

            case (st_q[i])
                E_FREE: begin
                    if (alloc_hit_v[i]) begin
                        addr_d[i]   = alloc_addr;
                        state_d[i]  = alloc_state;
                        req_id_d[i] = alloc_req_id;
                        cnt_d[i]    = alloc_invack;
`ifdef LLC_MSHR_WORD_MASK_EN
                        mask_d[i]   = alloc_word_mask;
`endif
                        st_d[i]     = (alloc_invack == '0) ? E_DONE : E_WAIT;
                    end
                end
                E_WAIT: begin
                    if (ack_zero_v[i]) st_d[i] = E_DONE;
                end
                E_DONE: begin
                    // A fresh zero crossing in the same cycle re-queues the entry.
                    if (done_hit_v[i] && !ack_zero_v[i]) st_d[i] = E_HELD;
                end
                E_HELD: begin
                    if (ack_zero_v[i]) st_d[i] = E_DONE;
                end
                default: st_d[i] = E_FREE;
            endcase

            // Free overrides any other event on the same entry.
            if (free_hit_v[i]) begin
                st_d[i] = E_FREE;
            end
        end
    end

    // Entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MSHR; i++) begin
                st_q[i]     <= E_FREE;
                addr_q[i]   <= '0;
                state_q[i]  <= '0;
                req_id_q[i] <= '0;
                cnt_q[i]    <= '0;
`ifdef LLC_MSHR_WORD_MASK_EN
                mask_q[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                st_q[i]     <= st_d[i];
                addr_q[i]   <= addr_d[i];
                state_q[i]  <= state_d[i];
                req_id_q[i] <= req_id_d[i];
                cnt_q[i]    <= cnt_d[i];
`ifdef LLC_MSHR_WORD_MASK_EN
                mask_q[i]   <= mask_d[i];
`endif
            end
        end
    end

endmodule
